// File: rtl/mc_controller.sv
// Multicycle controller for a small ARM-like datapath.
// Sequences each instruction through fetch, decode, execute/memory and writeback states,
// decodes the data-processing command into an ALU operation, keeps the {V,C,N,Z} flags
// register and gates writes with the instruction's condition, latched once per instruction.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   instr_cond        Instr[31:28] condition field
//   instr_op          Instr[27:26] instruction class
//   instr_funct       Instr[25:20] function field (I bit, command, S/L bit)
//   instr_rd          Instr[15:12] destination register
//   alu_flags         {V,C,N,Z} produced by the ALU this cycle
//   pc_write, mem_write, reg_write, ir_write, adr_src    write enables / address select
//   result_src, alu_src_b, imm_src, reg_src              2-bit datapath selects
//   alu_src_a, alu_control                               ALU operand A select, ALU op
module mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] instr_cond,
  input  logic [1:0] instr_op,
  input  logic [5:0] instr_funct,
  input  logic [3:0] instr_rd,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic       alu_src_a,
  output logic [2:0] alu_control
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  logic [3:0] state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_q, cond_d;

  // Command decode
  logic [2:0] dec_alu;
  logic       no_write;
  logic       cmd_legal;
  logic       cmd_is_cmp;
  logic       cmd_is_logic;

  always_comb begin
    dec_alu      = 3'b000;
    no_write     = 1'b0;
    cmd_legal    = 1'b1;
    cmd_is_cmp   = 1'b0;
    cmd_is_logic = 1'b0;
    case (instr_funct[4:1])
      4'b0100: dec_alu = 3'b000;
      4'b0010: dec_alu = 3'b001;
      4'b0000: begin
        dec_alu      = 3'b010;
        cmd_is_logic = 1'b1;
      end
      4'b1100: begin
        dec_alu      = 3'b011;
        cmd_is_logic = 1'b1;
      end
      4'b1010: begin
        dec_alu    = 3'b001;
        no_write   = 1'b1;
        cmd_is_cmp = 1'b1;
      end
      default: begin
        no_write  = 1'b1;
        cmd_legal = 1'b0;
      end
    endcase
  end

  // Condition evaluation against the architectural flags
  logic flag_v, flag_c, flag_n, flag_z;
  logic cond_ex;

  assign {flag_v, flag_c, flag_n, flag_z} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (instr_cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Condition is latched in DECODE so a flag update in EXECUTE cannot change the
  // gating of this instruction's own writeback.
  assign cond_d = (state_q == S_DECODE) ? cond_ex : cond_q;

  logic in_exec;
  logic flag_upd;

  assign in_exec  = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
  assign flag_upd = in_exec & cond_q & cmd_legal & (instr_funct[0] | cmd_is_cmp);

  always_comb begin
    flags_d = flags_q;
    if (flag_upd) begin
      if (cmd_is_logic) begin
        flags_d = {flags_q[3:2], alu_flags[1:0]};
      end else begin
        flags_d = alu_flags;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (instr_op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = instr_funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = instr_funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cond_q  <= cond_d;
    end
  end

  // Datapath controls
  assign imm_src = instr_op;
  assign reg_src = {(instr_op == 2'b01), (instr_op == 2'b10)};

  always_comb begin
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_b   = 2'b00;
    alu_src_a   = 1'b0;
    alu_control = 3'b000;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = cond_q;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = cond_q;
      end
      S_EXECUTER: alu_control = dec_alu;
      S_EXECUTEI: begin
        alu_src_b   = 2'b01;
        alu_control = dec_alu;
      end
      S_ALUWB: begin
        reg_write = cond_q & ~no_write;
        pc_write  = cond_q & ~no_write & (instr_rd == 4'b1111);
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_q;
      end
      default: ;
    endcase
    // Architectural writes are blocked for the whole reset cycle
    if (!rst_n) begin
      pc_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      ir_write  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Cycle-by-cycle vector bench for mc_controller. Each record gives one cycle's inputs and
// the expected output word for that cycle; records are built by small per-instruction
// helpers with hand-chosen expected enables.
module tb_mc_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] instr_cond;
  logic [1:0] instr_op;
  logic [5:0] instr_funct;
  logic [3:0] instr_rd;
  logic [3:0] alu_flags;
  logic       pc_write, mem_write, reg_write, ir_write, adr_src;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src;
  logic       alu_src_a;
  logic [2:0] alu_control;

  mc_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_cond  (instr_cond),
    .instr_op    (instr_op),
    .instr_funct (instr_funct),
    .instr_rd    (instr_rd),
    .alu_flags   (alu_flags),
    .pc_write    (pc_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .ir_write    (ir_write),
    .adr_src     (adr_src),
    .result_src  (result_src),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .reg_src     (reg_src),
    .alu_src_a   (alu_src_a),
    .alu_control (alu_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // base word: {pc_write, mem_write, reg_write, ir_write, adr_src,
  //             result_src[1:0], alu_src_b[1:0], alu_src_a, alu_control[2:0]}
  localparam logic [12:0] FETCH_B   = 13'b1_0_0_1_0_10_10_1_000;
  localparam logic [12:0] DECODE_B  = 13'b0_0_0_0_0_10_10_1_000;
  localparam logic [12:0] RST_B     = 13'b0_0_0_0_0_10_10_1_000;
  localparam logic [12:0] MEMADR_B  = 13'b0_0_0_0_0_00_01_0_000;
  localparam logic [12:0] MEMREAD_B = 13'b0_0_0_0_1_00_00_0_000;

  typedef struct {
    logic        rst_n;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  af;
    logic [12:0] base;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;
  logic done;

  function automatic logic [12:0] bs(input logic pcw, input logic memw, input logic regw,
                                     input logic irw, input logic adr, input logic [1:0] res,
                                     input logic [1:0] srcb, input logic srca,
                                     input logic [2:0] alu);
    return {pcw, memw, regw, irw, adr, res, srcb, srca, alu};
  endfunction

  task automatic push(input logic r, input logic [3:0] c, input logic [1:0] op,
                      input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af,
                      input logic [12:0] base, input string nm);
    vec_t v;
    v.rst_n = r; v.cond = c; v.op = op; v.funct = f; v.rd = rd; v.af = af;
    v.base = base; v.name = nm;
    vecs.push_back(v);
  endtask

  // Data-processing instruction: FETCH, DECODE, EXECUTER/EXECUTEI, ALUWB
  task automatic dp(input logic [3:0] c, input logic [5:0] f, input logic [3:0] rd,
                    input logic [3:0] af, input logic [2:0] alu, input logic rw,
                    input logic pw, input string nm);
    push(1'b1, c, 2'b00, f, rd, af, FETCH_B, {nm, "/fetch"});
    push(1'b1, c, 2'b00, f, rd, af, DECODE_B, {nm, "/decode"});
    push(1'b1, c, 2'b00, f, rd, af,
         bs(0, 0, 0, 0, 0, 2'b00, f[5] ? 2'b01 : 2'b00, 0, alu), {nm, "/exec"});
    push(1'b1, c, 2'b00, f, rd, af, bs(pw, 0, rw, 0, 0, 2'b00, 2'b00, 0, 3'b000),
         {nm, "/aluwb"});
  endtask

  task automatic br(input logic [3:0] c, input logic pw, input string nm);
    push(1'b1, c, 2'b10, 6'b0, 4'b0, 4'b0, FETCH_B, {nm, "/fetch"});
    push(1'b1, c, 2'b10, 6'b0, 4'b0, 4'b0, DECODE_B, {nm, "/decode"});
    push(1'b1, c, 2'b10, 6'b0, 4'b0, 4'b0, bs(pw, 0, 0, 0, 0, 2'b10, 2'b01, 0, 3'b000),
         {nm, "/branch"});
  endtask

  task automatic mem(input logic [3:0] c, input logic [5:0] f, input logic w, input string nm);
    push(1'b1, c, 2'b01, f, 4'b0010, 4'b0, FETCH_B, {nm, "/fetch"});
    push(1'b1, c, 2'b01, f, 4'b0010, 4'b0, DECODE_B, {nm, "/decode"});
    push(1'b1, c, 2'b01, f, 4'b0010, 4'b0, MEMADR_B, {nm, "/memadr"});
    if (f[0]) begin
      push(1'b1, c, 2'b01, f, 4'b0010, 4'b0, MEMREAD_B, {nm, "/memread"});
      push(1'b1, c, 2'b01, f, 4'b0010, 4'b0, bs(0, 0, w, 0, 0, 2'b01, 2'b00, 0, 3'b000),
           {nm, "/memwb"});
    end else begin
      push(1'b1, c, 2'b01, f, 4'b0010, 4'b0, bs(0, w, 0, 0, 1, 2'b00, 2'b00, 0, 3'b000),
           {nm, "/memwrite"});
    end
  endtask

  initial begin
    done = 1'b0;
    #100000;
    if (!done) begin
      $display("FAIL timeout: vector run did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks + 1,
               n_fail + 1);
      $finish;
    end
  end

  initial begin
    logic [16:0] act, exp;
    n_checks = 0;
    n_fail   = 0;

    // Reset cycle observed after the state has been reset to FETCH
    push(1'b0, 4'b1110, 2'b00, 6'b001000, 4'b0001, 4'b0, RST_B, "reset");
    dp(4'b1110, 6'b001000, 4'b0001, 4'b0000, 3'b000, 1, 0, "add");
    br(4'b0000, 0, "beq_flags0");
    dp(4'b1110, 6'b010101, 4'b1111, 4'b0001, 3'b001, 0, 0, "cmp_z");
    br(4'b0000, 1, "beq_taken");
    mem(4'b1110, 6'b011001, 1, "ldr");
    mem(4'b1110, 6'b011000, 1, "str");
    dp(4'b1110, 6'b010101, 4'b0000, 4'b1100, 3'b001, 0, 0, "cmp_vc");
    dp(4'b1110, 6'b000001, 4'b0011, 4'b0011, 3'b010, 1, 0, "ands");
    br(4'b0000, 1, "beq_z1");
    br(4'b0011, 0, "bcc_c1");
    br(4'b0111, 0, "bvc_v1");
    br(4'b1010, 1, "bge_nv");
    // ADDS aborted by reset during EXECUTEI
    push(1'b1, 4'b1110, 2'b00, 6'b101001, 4'b0100, 4'b0101, FETCH_B, "adds_rst/fetch");
    push(1'b1, 4'b1110, 2'b00, 6'b101001, 4'b0100, 4'b0101, DECODE_B, "adds_rst/decode");
    push(1'b0, 4'b1110, 2'b00, 6'b101001, 4'b0100, 4'b0101,
         bs(0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 3'b000), "adds_rst/execi");
    br(4'b0000, 0, "beq_after_rst");
    // ADD to PC with reset asserted in ALUWB: enables forced low
    push(1'b1, 4'b1110, 2'b00, 6'b001000, 4'b1111, 4'b0, FETCH_B, "add_rst/fetch");
    push(1'b1, 4'b1110, 2'b00, 6'b001000, 4'b1111, 4'b0, DECODE_B, "add_rst/decode");
    push(1'b1, 4'b1110, 2'b00, 6'b001000, 4'b1111, 4'b0,
         bs(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000), "add_rst/exec");
    push(1'b0, 4'b1110, 2'b00, 6'b001000, 4'b1111, 4'b0,
         bs(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000), "add_rst/aluwb");
    dp(4'b1110, 6'b011000, 4'b1111, 4'b0000, 3'b011, 1, 1, "orr_pc");
    dp(4'b1111, 6'b001000, 4'b1111, 4'b0000, 3'b000, 0, 0, "add_nv");
    mem(4'b1111, 6'b011000, 0, "str_nv");
    dp(4'b1110, 6'b000011, 4'b0101, 4'b1111, 3'b000, 0, 0, "illegal");
    br(4'b0000, 0, "beq_illegal");
    push(1'b1, 4'b1110, 2'b11, 6'b0, 4'b0, 4'b0, FETCH_B, "op11/fetch");
    push(1'b1, 4'b1110, 2'b11, 6'b0, 4'b0, 4'b0, DECODE_B, "op11/decode");
    dp(4'b1110, 6'b010101, 4'b0000, 4'b0001, 3'b001, 0, 0, "cmp_z2");
    // EQ-conditional ADDS clears Z in EXECUTE but its own writeback stays enabled
    dp(4'b0000, 6'b001001, 4'b0100, 4'b0000, 3'b000, 1, 0, "addseq");
    br(4'b0000, 0, "beq_z_cleared");

    rst_n       = 1'b0;
    instr_cond  = 4'b0;
    instr_op    = 2'b0;
    instr_funct = 6'b0;
    instr_rd    = 4'b0;
    alu_flags   = 4'b0;
    repeat (2) @(posedge clk);
    #1;

    act = {pc_write, mem_write, reg_write, ir_write, adr_src, result_src, alu_src_b,
           alu_src_a, alu_control, imm_src, reg_src};
    n_checks++;
    if (act !== {RST_B, 4'b0000}) begin
      n_fail++;
      $display("FAIL initial reset state: got %b expected %b", act, {RST_B, 4'b0000});
    end

    foreach (vecs[i]) begin
      rst_n       = vecs[i].rst_n;
      instr_cond  = vecs[i].cond;
      instr_op    = vecs[i].op;
      instr_funct = vecs[i].funct;
      instr_rd    = vecs[i].rd;
      alu_flags   = vecs[i].af;
      @(negedge clk);
      exp = {vecs[i].base, vecs[i].op, (vecs[i].op == 2'b01), (vecs[i].op == 2'b10)};
      act = {pc_write, mem_write, reg_write, ir_write, adr_src, result_src, alu_src_b,
             alu_src_a, alu_control, imm_src, reg_src};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s (vec %0d): got %b expected %b", vecs[i].name, i, act, exp);
      end
      @(posedge clk);
      #1;
    end

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
